// File: rtl/pwm_pkg.sv
// Shared frame-buffer geometry and enums for the pwm block and its write-port arbiter.
// Pure declarations: no logic, no latency, no flow control.
package pwm_pkg;

    localparam int FB_AW     = 11;
    localparam int FB_DW     = 8;
    localparam int FRAME_LEN = 1536;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_STREAM,
        GNT_CLEAR
    } gnt_src_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } fb_state_t;

endpackage

// File: rtl/pwm_rr_arb2.sv
// Two-requester round-robin arbiter (req[0]=CPU, req[1]=stream) with registered preference.
// Grant is combinational from req/pref; no grant at all while en is low.
module pwm_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       pref
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt[pref] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    // Preference flips to whoever was not just served, so a lone winner also hands over.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pref <= 1'b0;
        end else if (gnt[0]) begin
            pref <= 1'b1;
        end else if (gnt[1]) begin
            pref <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_fb_arbiter.sv
// Sole writer of the pwm frame buffer: arbitrates CPU, stream loader and clear engine.
// One registered write per cycle (grant -> we next cycle); clear stalls both requesters.
module pwm_fb_arbiter
    import pwm_pkg::*;
#(
    parameter int AW        = FB_AW,
    parameter int DW        = FB_DW,
    parameter int FRAME_LEN = pwm_pkg::FRAME_LEN
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ack,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic          s_sof,
    output logic          s_ready,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_value,
    output logic          busy,
    output logic          frame_done,
    output logic          clr_done,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] din,
    output logic          we
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);
    localparam logic [AW:0]   CLR_END   = (AW+1)'(FRAME_LEN);

    fb_state_t     state, nxt_state;
    gnt_src_t      gsel;
    logic          arb_en;
    logic [1:0]    arb_req;
    logic [1:0]    arb_gnt;
    logic          rr_pref;

    logic [AW-1:0] sptr;
    logic [AW-1:0] s_wa;
    logic          s_last;

    logic [AW:0]   clr_cnt;
    logic [DW-1:0] clr_val;
    logic [AW-1:0] clr_wa;
    logic [DW-1:0] clr_wd;
    logic          cpu_in_range;

    // A CPU request is still high on its ack cycle; masking it there avoids a double grant.
    assign arb_req = {s_valid, cpu_req & ~cpu_ack};

    pwm_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   (arb_req),
        .gnt   (arb_gnt),
        .pref  (rr_pref)
    );

    assign s_ready = reset && (state == ST_IDLE) && !clr_start && (!cpu_req || rr_pref);
    assign busy    = (state == ST_CLEAR);

    assign s_wa         = s_sof ? '0 : sptr;
    assign s_last       = (s_wa == LAST_ADDR);
    assign cpu_in_range = ({1'b0, cpu_addr} < CLR_END);

    // The clr_start cycle itself issues address 0 with the live value; later ones use the latch.
    assign clr_wa = (state == ST_IDLE) ? '0 : clr_cnt[AW-1:0];
    assign clr_wd = (state == ST_IDLE) ? clr_value : clr_val;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        gsel      = GNT_NONE;
        arb_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_start) begin
                    gsel      = GNT_CLEAR;
                    nxt_state = ST_CLEAR;
                end else begin
                    arb_en = 1'b1;
                    if (arb_gnt[0]) begin
                        gsel = GNT_CPU;
                    end else if (arb_gnt[1]) begin
                        gsel = GNT_STREAM;
                    end
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == CLR_END) begin
                    nxt_state = ST_IDLE;
                end else begin
                    gsel = GNT_CLEAR;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr       <= '0;
            din        <= '0;
            we         <= 1'b0;
            cpu_ack    <= 1'b0;
            frame_done <= 1'b0;
            clr_done   <= 1'b0;
            sptr       <= '0;
            clr_cnt    <= '0;
            clr_val    <= '0;
        end else begin
            we         <= 1'b0;
            cpu_ack    <= 1'b0;
            frame_done <= 1'b0;
            clr_done   <= 1'b0;
            case (gsel)
                GNT_CPU: begin
                    cpu_ack <= 1'b1;
                    if (cpu_in_range) begin
                        we   <= 1'b1;
                        addr <= cpu_addr;
                        din  <= cpu_din;
                    end
                end
                GNT_STREAM: begin
                    we         <= 1'b1;
                    addr       <= s_wa;
                    din        <= s_data;
                    sptr       <= s_last ? '0 : s_wa + AW'(1);
                    frame_done <= s_last;
                end
                GNT_CLEAR: begin
                    we       <= 1'b1;
                    addr     <= clr_wa;
                    din      <= clr_wd;
                    clr_done <= (clr_wa == LAST_ADDR);
                    clr_cnt  <= {1'b0, clr_wa} + (AW+1)'(1);
                    if (state == ST_IDLE) begin
                        clr_val <= clr_value;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pwm_fb_arbiter.md
Name: pwm_fb_arbiter

Overview:
- Sole writer of the pwm frame-buffer write port (addr/din/we), sharing it between three sources.
- Sources: a CPU single-write port, a streaming frame loader (valid/ready, sequential addresses) and an internal clear engine.
- Issues at most one buffer write per clk cycle.
- Sits between the bus/UART loader logic and the pwm block, in the pwm clk domain.

Parameters:
- AW, 11, frame-buffer address width.
- DW, 8, frame-buffer data width.
- FRAME_LEN, 1536, number of valid buffer locations (8x8x8 RGB); addresses 0..FRAME_LEN-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU write request; held until cpu_ack.
- cpu_addr  in  AW  CPU write address.
- cpu_din  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle grant pulse for the CPU request.
- s_valid  in  1  stream beat valid.
- s_data  in  DW  stream beat data.
- s_sof  in  1  beat is the first of a frame; qualified by s_valid.
- s_ready  out  1  stream beat accepted when s_valid && s_ready.
- clr_start  in  1  pulse: fill the whole buffer with clr_value.
- clr_value  in  DW  fill value, sampled on the clr_start cycle.
- busy  out  1  high while the clear engine runs.
- frame_done  out  1  one-cycle pulse after the last stream beat of a frame is written.
- clr_done  out  1  one-cycle pulse after the last clear write.
- addr  out  AW  to pwm addr.
- din  out  DW  to pwm din.
- we  out  1  to pwm we; one write per cycle.

Behaviour:
- Reset (reset==0 at a clk edge) drives all outputs to 0. It also clears the stream pointer, the round-robin pointer (next preference = CPU) and the FSM (state IDLE).
- Reset mid-clear aborts the clear immediately; clr_done does not fire.
- FSM has two states, IDLE and CLEAR.
- IDLE arbitration, per cycle:
  - Candidates are cpu_req and s_valid.
  - If both request, the one not granted last wins (round-robin). A lone requester always wins.
  - The grant is registered: addr/din/we are valid on the cycle after the grant decision. cpu_ack pulses on that same cycle as we.
  - cpu_req must drop the cycle after cpu_ack. It is re-evaluated as a new request if still high.
- s_ready is combinational: IDLE && !clr_start && (!cpu_req || rr_pref==STREAM).
- Stream address pointer sptr (AW bits):
  - An accepted beat writes addr = s_sof ? 0 : sptr.
  - After the beat, sptr = (written address + 1).
  - When the written address equals FRAME_LEN-1: sptr wraps to 0 and frame_done pulses together with that beat's we.
- CPU writes with cpu_addr >= FRAME_LEN are acked (same timing) with we=0; no buffer write occurs.
- clr_start in IDLE:
  - Has priority over both requesters that cycle; they are not granted.
  - Enters CLEAR and latches clr_value. busy=1 from the next cycle.
- CLEAR:
  - Writes addresses 0,1,...,FRAME_LEN-1 with the latched value, one per cycle, we=1 each cycle.
  - cpu_ack stays 0 and s_ready stays 0; requests wait.
  - On the last write, clr_done pulses with that we. Returns to IDLE and busy=0 on the next cycle.
  - Clear duration is exactly FRAME_LEN write cycles.
- clr_start during CLEAR is ignored.
- The stream pointer is not modified by a clear.
- we is never high on two sources simultaneously. The outputs hold their last addr/din when we=0.

Decomposition:
- Shared package (pwm_pkg) holds:
  - FB_AW=11, FB_DW=8, FRAME_LEN=1536 constants, shared with pwm.
  - Grant-source enum {GNT_NONE, GNT_CPU, GNT_STREAM, GNT_CLEAR}.
  - FSM state enum {ST_IDLE, ST_CLEAR}.
- Natural sub-module: pwm_rr_arb2, a 2-requester round-robin arbiter with registered preference and a grant-enable input.
- Clear counter, stream pointer and output register stay in the top module.

Test Plan:
- Reset release, then a single CPU write, cpu_addr=0x005, cpu_din=0xA5:
  - Next cycle: we=1, addr=0x005, din=0xA5, cpu_ack=1.
  - All outputs were 0 during reset.
- Stream 1536 beats, first with s_sof, data = index mod 256, s_valid always high:
  - Addresses 0..1535 in order at 1/cycle.
  - frame_done pulses exactly once, with addr=1535.
  - The next beat (no s_sof) writes addr 0.
- CPU and stream both requesting continuously:
  - Grants alternate CPU, STREAM, CPU...
  - Each CPU ack is separated by exactly one stream write; no cycle with we=0.
- clr_start with clr_value=0x3C while the stream is mid-frame at sptr=100:
  - busy=1 for 1536 cycles, addresses 0..1535 all =0x3C, clr_done on addr 1535.
  - The stream then resumes at addr 100.
- CPU write to cpu_addr=1600 -> cpu_ack=1, we=0.
- clr_start during CLEAR -> ignored.
- Reset at clear write 500 -> all outputs 0 the next cycle and no clr_done.
